channel_integrator: RTL and testbench

Parametrised per-channel saturating integrator for the VGA display path. It takes one binary sample per channel per active pixel, typically the 3-bit GPIO comparator word read back from display RAM. It keeps one up/down saturating accumulator per channel and emits left-justified colour levels with per-channel masking and blanking. It sits between the display RAM read port and the RGB output registers, and generalises the fixed 3×5-bit integrator to N channels, arbitrary width, programmable steps, selectable modes and frame-synchronous clearing.

---
 rtl/integrator_pkg.sv | 20 ++
 rtl/sat_step.sv | 56 +++++
 rtl/channel_integrator.sv | 108 ++++++++++
 tb/tb_channel_integrator.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/integrator_pkg.sv
// rtl/integrator_pkg.sv - shared types and helpers for channel_integrator
//
// Purpose : update-mode encoding and the saturation ceiling helper used by
//           the per-channel integrator and its next-state logic.
package integrator_pkg;

    // Mode encoding as driven on the mode port; the unused code 3 is
    // handled as FREEZE by the consumers.
    typedef enum logic [1:0] {
        MODE_INTEGRATE = 2'd0,
        MODE_DIRECT    = 2'd1,
        MODE_FREEZE    = 2'd2
    } mode_t;

    // All-ones value of a w-bit accumulator (2^w - 1), valid for 1 <= w <= 64.
    function automatic logic [63:0] max_level(input int unsigned w);
        return {64{1'b1}} >> (64 - w);
    endfunction

endpackage

// File: rtl/sat_step.sv
// rtl/sat_step.sv - one channel's saturating accumulator next-state logic
//
// Purpose : computes the next accumulator value for one channel from the
//           captured sample bit, mode and steps; purely combinational.
// Ports   : acc       in  W  current accumulator
//           sample    in  1  captured sample bit for this channel
//           mode      in  2  captured update mode
//           up_step   in  W  increment when sample is 1 (INTEGRATE)
//           down_step in  W  decrement when sample is 0 (INTEGRATE)
//           update    in  1  captured sample is valid
//           clear     in  1  frame clear; overrides any update
//           next      out W  next accumulator value
module sat_step
    import integrator_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] acc,
    input  logic         sample,
    input  logic [1:0]   mode,
    input  logic [W-1:0] up_step,
    input  logic [W-1:0] down_step,
    input  logic         update,
    input  logic         clear,
    output logic [W-1:0] next
);

    localparam logic [W-1:0] MAX = W'(max_level(W));

    // One extra bit catches the carry out of the add and the borrow of the
    // subtract, so saturation never sees a wrapped value.
    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum  = {1'b0, acc} + {1'b0, up_step};
        diff = {1'b0, acc} - {1'b0, down_step};
        next = acc;
        if (clear) begin
            next = '0;
        end else if (update) begin
            case (mode_t'(mode))
                MODE_INTEGRATE: begin
                    if (sample) begin
                        next = sum[W] ? MAX : sum[W-1:0];
                    end else begin
                        next = diff[W] ? '0 : diff[W-1:0];
                    end
                end
                MODE_DIRECT: next = sample ? MAX : '0;
                default:     next = acc;
            endcase
        end
    end

endmodule

// File: rtl/channel_integrator.sv
// rtl/channel_integrator.sv - N-channel saturating integrator for the display path
//
// Purpose : captures one sample bit per channel, updates a saturating
//           accumulator per channel and emits left-justified, maskable,
//           blanked colour levels two cycles after the sample.
// Ports   : clock        in  1                 rising-edge clock
//           reset        in  1                 synchronous, active-high
//           in_valid     in  1                 sample strobe
//           in_bits      in  CHANNELS          sample bit per channel
//           frame_start  in  1                 frame marker (clears when enabled)
//           mode         in  2                 update mode, travels with sample
//           up_step      in  ACC_W             increment for bit=1
//           down_step    in  ACC_W             decrement for bit=0
//           chan_mask    in  CHANNELS          1 forces a channel's level to 0
//           acc_level    out CHANNELS*ACC_W    raw accumulators
//           out_valid    out 1                 out_level belongs to a sample
//           out_level    out CHANNELS*OUT_W    colour levels
module channel_integrator
    import integrator_pkg::*;
#(
    parameter int CHANNELS       = 3,
    parameter int ACC_W          = 5,
    parameter int OUT_W          = 8,
    parameter bit CLEAR_ON_FRAME = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [CHANNELS-1:0]       in_bits,
    input  logic                      frame_start,
    input  logic [1:0]                mode,
    input  logic [ACC_W-1:0]          up_step,
    input  logic [ACC_W-1:0]          down_step,
    input  logic [CHANNELS-1:0]       chan_mask,
    output logic [CHANNELS*ACC_W-1:0] acc_level,
    output logic                      out_valid,
    output logic [CHANNELS*OUT_W-1:0] out_level
);

    // Capture stage: every control input travels with its sample.
    logic                  s0_valid;
    logic [CHANNELS-1:0]   s0_bits;
    logic                  s0_frame_start;
    logic [1:0]            s0_mode;
    logic [ACC_W-1:0]      s0_up_step;
    logic [ACC_W-1:0]      s0_down_step;

    // Update stage: accumulators and the formatted level are loaded on the
    // same edge, so out_level always shows the post-update accumulator.
    logic [CHANNELS*ACC_W-1:0] acc_q;
    logic [CHANNELS*ACC_W-1:0] acc_d;
    logic                      s1_valid;
    logic [CHANNELS*OUT_W-1:0] level_q;
    logic [CHANNELS*OUT_W-1:0] level_d;

    logic frame_clear;
    assign frame_clear = CLEAR_ON_FRAME & s0_frame_start;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        sat_step #(
            .W (ACC_W)
        ) u_sat_step (
            .acc       (acc_q[i*ACC_W +: ACC_W]),
            .sample    (s0_bits[i]),
            .mode      (s0_mode),
            .up_step   (s0_up_step),
            .down_step (s0_down_step),
            .update    (s0_valid),
            .clear     (frame_clear),
            .next      (acc_d[i*ACC_W +: ACC_W])
        );

        // Mask is taken live here rather than pipelined with the sample;
        // an invalid slot blanks to 0.
        assign level_d[i*OUT_W +: OUT_W] = (s0_valid && !chan_mask[i])
            ? (OUT_W'(acc_d[i*ACC_W +: ACC_W]) << (OUT_W - ACC_W))
            : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s0_valid       <= 1'b0;
            s0_bits        <= '0;
            s0_frame_start <= 1'b0;
            s0_mode        <= '0;
            s0_up_step     <= '0;
            s0_down_step   <= '0;
            acc_q          <= '0;
            s1_valid       <= 1'b0;
            level_q        <= '0;
        end else begin
            s0_valid       <= in_valid;
            s0_bits        <= in_bits;
            s0_frame_start <= frame_start;
            s0_mode        <= mode;
            s0_up_step     <= up_step;
            s0_down_step   <= down_step;
            acc_q          <= acc_d;
            s1_valid       <= s0_valid;
            level_q        <= level_d;
        end
    end

    assign acc_level = acc_q;
    assign out_valid = s1_valid;
    assign out_level = level_q;

endmodule

// File: tb/tb_channel_integrator.sv
// tb/tb_channel_integrator.sv - directed self-checking bench for channel_integrator
module tb_channel_integrator;

    localparam int CH = 3;
    localparam int AW = 5;
    localparam int OW = 8;
    localparam logic [7:0] F8 = 8'hF8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic [CH-1:0]   in_bits = '0;
    logic            frame_start = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [AW-1:0]   up_step = '0;
    logic [AW-1:0]   down_step = '0;
    logic [CH-1:0]   chan_mask = '0;

    logic [CH*AW-1:0] acc_level;
    logic             out_valid;
    logic [CH*OW-1:0] out_level;
    logic [CH*AW-1:0] nc_acc_level;
    logic             nc_out_valid;
    logic [CH*OW-1:0] nc_out_level;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    channel_integrator #(
        .CHANNELS(CH), .ACC_W(AW), .OUT_W(OW), .CLEAR_ON_FRAME(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_bits(in_bits),
        .frame_start(frame_start), .mode(mode), .up_step(up_step),
        .down_step(down_step), .chan_mask(chan_mask), .acc_level(acc_level),
        .out_valid(out_valid), .out_level(out_level)
    );

    channel_integrator #(
        .CHANNELS(CH), .ACC_W(AW), .OUT_W(OW), .CLEAR_ON_FRAME(1'b0)
    ) dut_nc (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_bits(in_bits),
        .frame_start(frame_start), .mode(mode), .up_step(up_step),
        .down_step(down_step), .chan_mask(chan_mask), .acc_level(nc_acc_level),
        .out_valid(nc_out_valid), .out_level(nc_out_level)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_bits = 3'b111; mode = 2'd1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || out_level !== '0 || acc_level !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: got valid=%b level=%h acc=%h, want 0/0/0",
                         k, out_valid, out_level, acc_level);
            end
        end
        reset = 1'b0; in_valid = 1'b0; in_bits = '0; mode = 2'd0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || out_level !== '0 || acc_level !== '0) begin
                errors++;
                $display("FAIL post_reset[%0d]: got valid=%b level=%h acc=%h, want 0/0/0",
                         k, out_valid, out_level, acc_level);
            end
        end
    endtask

    task automatic test_sat_up();
        logic [CH*AW-1:0] ea;
        logic [CH*OW-1:0] el;
        logic             ev;
        int               e;
        mode = 2'd0; up_step = 5'd1; down_step = 5'd0; in_bits = 3'b001; in_valid = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            e  = (k - 1 > 31) ? 31 : k - 1;
            ev = (k >= 2);
            ea = {5'd0, 5'd0, 5'(e)};
            el = ev ? {8'd0, 8'd0, 8'(e << 3)} : '0;
            checks++;
            if (out_valid !== ev || acc_level !== ea || out_level !== el) begin
                errors++;
                $display("FAIL sat_up[%0d]: got valid=%b acc=%h level=%h, want %b/%h/%h",
                         k, out_valid, acc_level, out_level, ev, ea, el);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || acc_level !== {5'd0, 5'd0, 5'd31} ||
            out_level !== {8'd0, 8'd0, F8}) begin
            errors++;
            $display("FAIL sat_up_hold: got valid=%b acc=%h level=%h, want 1/1f/f8",
                     out_valid, acc_level, out_level);
        end
        step();
    endtask

    task automatic test_sat_down();
        logic [CH*AW-1:0] ea;
        logic [CH*OW-1:0] el;
        logic             ev;
        int               e;
        in_bits = 3'b000; down_step = 5'd4; up_step = 5'd0; in_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            e  = 31 - 4 * (k - 1);
            if (e < 0) e = 0;
            ev = (k >= 2);
            ea = {5'd0, 5'd0, 5'(e)};
            el = ev ? {8'd0, 8'd0, 8'(e << 3)} : '0;
            checks++;
            if (out_valid !== ev || acc_level !== ea || out_level !== el) begin
                errors++;
                $display("FAIL sat_down[%0d]: got valid=%b acc=%h level=%h, want %b/%h/%h",
                         k, out_valid, acc_level, out_level, ev, ea, el);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || acc_level !== '0 || out_level !== '0) begin
            errors++;
            $display("FAIL sat_down_floor: got valid=%b acc=%h level=%h, want 1/0/0",
                     out_valid, acc_level, out_level);
        end
        step();
    endtask

    task automatic test_mask_gap();
        in_valid = 1'b1; mode = 2'd1; in_bits = 3'b001; chan_mask = 3'b001;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || acc_level !== {5'd0, 5'd0, 5'd31} || out_level !== '0) begin
            errors++;
            $display("FAIL mask: got valid=%b acc=%h level=%h, want 1/1f/0",
                     out_valid, acc_level, out_level);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || out_level !== '0 || acc_level !== {5'd0, 5'd0, 5'd31}) begin
                errors++;
                $display("FAIL gap[%0d]: got valid=%b level=%h acc=%h, want 0/0/1f",
                         k, out_valid, out_level, acc_level);
            end
        end
        chan_mask = 3'b000; mode = 2'd0; up_step = 5'd1; in_bits = 3'b001; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_level !== {8'd0, 8'd0, F8} ||
            acc_level !== {5'd0, 5'd0, 5'd31}) begin
            errors++;
            $display("FAIL unmask: got valid=%b level=%h acc=%h, want 1/f8/1f",
                     out_valid, out_level, acc_level);
        end
        step();
    endtask

    task automatic test_frame_clear();
        in_valid = 1'b1; mode = 2'd1; in_bits = 3'b111;
        step();
        mode = 2'd0; up_step = 5'd1; frame_start = 1'b1;
        step();
        frame_start = 1'b0; in_valid = 1'b0;
        checks++;
        if (acc_level !== {3{5'd31}} || nc_acc_level !== {3{5'd31}}) begin
            errors++;
            $display("FAIL preclear: got acc=%h nc_acc=%h, want 7fff/7fff",
                     acc_level, nc_acc_level);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || acc_level !== '0 || out_level !== '0) begin
            errors++;
            $display("FAIL frame_clear: got valid=%b acc=%h level=%h, want 1/0/0",
                     out_valid, acc_level, out_level);
        end
        checks++;
        if (nc_out_valid !== 1'b1 || nc_acc_level !== {3{5'd31}} ||
            nc_out_level !== {3{F8}}) begin
            errors++;
            $display("FAIL no_clear: got valid=%b acc=%h level=%h, want 1/7fff/f8f8f8",
                     nc_out_valid, nc_acc_level, nc_out_level);
        end
        step();
    endtask

    task automatic test_modes();
        logic [CH*AW-1:0] ea;
        logic [CH*OW-1:0] el;
        logic             ev;
        ea = {5'd31, 5'd0, 5'd31};
        el = {F8, 8'd0, F8};
        in_valid = 1'b1; mode = 2'd1; in_bits = 3'b101; up_step = 5'd1; down_step = 5'd1;
        step();
        mode = 2'd2; in_bits = 3'b010;
        step();
        checks++;
        if (out_valid !== 1'b1 || acc_level !== ea || out_level !== el) begin
            errors++;
            $display("FAIL direct: got valid=%b acc=%h level=%h, want 1/%h/%h",
                     out_valid, acc_level, out_level, ea, el);
        end
        for (int k = 0; k < 4; k++) begin
            in_bits = (k % 2 == 0) ? 3'b101 : 3'b010;
            step();
            checks++;
            if (out_valid !== 1'b1 || acc_level !== ea || out_level !== el) begin
                errors++;
                $display("FAIL freeze[%0d]: got valid=%b acc=%h level=%h, want 1/%h/%h",
                         k, out_valid, acc_level, out_level, ea, el);
            end
        end
        mode = 2'd3;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k % 2 == 0);
            in_bits  = (k % 2 == 0) ? 3'b010 : 3'b101;
            step();
            ev = (k == 0) ? 1'b1 : ((k - 1) % 2 == 0);
            checks++;
            if (out_valid !== ev || acc_level !== ea || out_level !== (ev ? el : '0)) begin
                errors++;
                $display("FAIL mode3[%0d]: got valid=%b acc=%h level=%h, want %b/%h/%h",
                         k, out_valid, acc_level, out_level, ev, ea, ev ? el : '0);
            end
        end
        in_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        int         exp_tab [8];
        pat     = 8'b0000_1011;
        exp_tab = '{5, 10, 7, 12, 9, 6, 3, 0};
        mode = 2'd0; up_step = 5'd5; down_step = 5'd3; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_bits = {1'b1, pat[k], 1'b1};
            step();
            if (k >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || acc_level !== {5'd31, 5'(exp_tab[k-1]), 5'd31} ||
                    out_level !== {F8, 8'(exp_tab[k-1] << 3), F8}) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got valid=%b acc=%h level=%h, want ch1=%0d",
                             k, out_valid, acc_level, out_level, exp_tab[k-1]);
                end
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || acc_level !== {5'd31, 5'd0, 5'd31} ||
            out_level !== {F8, 8'd0, F8}) begin
            errors++;
            $display("FAIL b2b_last: got valid=%b acc=%h level=%h, want ch1=0",
                     out_valid, acc_level, out_level);
        end
        step();
    endtask

    task automatic test_midstream_reset();
        in_valid = 1'b1; mode = 2'd1; in_bits = 3'b111;
        step();
        reset = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || acc_level !== '0 || out_level !== '0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b acc=%h level=%h, want 0/0/0",
                     out_valid, acc_level, out_level);
        end
        reset = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || acc_level !== '0) begin
                errors++;
                $display("FAIL mid_reset_drop[%0d]: got valid=%b acc=%h, want 0/0",
                         k, out_valid, acc_level);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sat_up();
        test_sat_down();
        test_mask_gap();
        test_frame_clear();
        test_modes();
        test_back_to_back();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
